param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/seg7_hex_decoder.sv | 32 +++
 rtl/param_sync_fifo.sv | 123 ++++++++++++
 tb/tb_param_sync_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: seven-segment hex glyphs (abcdefg, active-high)
// and the occupancy-counter width helper.
package fifo_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  // Occupancy ranges over 0..depth inclusive, hence depth+1 states.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex to seven-segment (abcdefg, active-high) decoder.
module seg7_hex_decoder
  import fifo_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered read data, status flags and sticky errors.
// Optional seven-segment readout of the last read nibble under PARAM_SYNC_FIFO_SEG7_EN.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned AF_LEVEL = DEPTH - 8,
  parameter int unsigned AE_LEVEL = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          rd_valid,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
`ifdef PARAM_SYNC_FIFO_SEG7_EN
  output logic [6:0]                    seg_out,
`endif
  output logic                          underflow
);

  localparam int unsigned CW = count_width(DEPTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, wr_ptr_next;
  logic [PW-1:0]    rd_ptr, rd_ptr_next;
  logic [CW-1:0]    count_next;
  logic             wr_acc, rd_acc;
  logic [31:0]      count_ext;

  assign count_ext    = 32'(count);
  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign almost_full  = (count_ext >= AF_LEVEL);
  assign almost_empty = (count_ext <= AE_LEVEL);

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_en);

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (wr_acc) begin
      wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_next = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    end
  end

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Storage is not reset; occupancy tracking alone keeps stale words unreachable.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rd_ptr];
      end
      // A write on an empty FIFO covers a simultaneous read, so that is not an underflow.
      if (wr_en && full && !rd_en) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty && !wr_en) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef PARAM_SYNC_FIFO_SEG7_EN
  logic [6:0] seg_next;

  seg7_hex_decoder u_seg7_hex_decoder (
    .hex (mem[rd_ptr][3:0]),
    .seg (seg_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_out <= SEG_0;
    end else if (rd_acc) begin
      seg_out <= seg_next;
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomised self-checking bench for param_sync_fifo against a queue-based reference model.
module tb_param_sync_fifo;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 128;
  localparam int unsigned AF = D - 8;
  localparam int unsigned AE = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         rd_en;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic [7:0]   count;
  logic         full, empty, almost_full, almost_empty, overflow, underflow;
`ifdef PARAM_SYNC_FIFO_SEG7_EN
  logic [6:0]   seg_out;
`endif

  param_sync_fifo #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
`ifdef PARAM_SYNC_FIFO_SEG7_EN
    .seg_out      (seg_out),
`endif
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_rd_data;
  logic         m_rd_valid, m_ovf, m_unf;
  logic [6:0]   m_seg;
  logic [6:0]   hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int n_chk = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic w, input logic [W-1:0] d,
                              input logic rr);
    bit m_full, m_empty, rd_ok, wr_ok;
    if (r) begin
      q.delete();
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
      m_seg      = hex_tab[0];
      return;
    end
    m_full  = (q.size() == D);
    m_empty = (q.size() == 0);
    rd_ok   = rr && !m_empty;
    wr_ok   = w && (!m_full || rr);
    if (w && m_full && !rr) m_ovf = 1'b1;
    if (rr && m_empty && !w) m_unf = 1'b1;
    m_rd_valid = rd_ok;
    if (rd_ok) begin
      m_rd_data = q.pop_front();
      m_seg     = hex_tab[m_rd_data[3:0]];
    end
    if (wr_ok) q.push_back(d);
  endtask

  task automatic step(input logic r, input logic w, input logic [W-1:0] d, input logic rr);
    reset   = r;
    wr_en   = w;
    wr_data = d;
    rd_en   = rr;
    @(posedge clock);
    model_update(r, w, d, rr);
    #1;
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      chk("count", int'(count), q.size());
      chk("full", int'(full), int'(q.size() == D));
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("almost_full", int'(almost_full), int'(q.size() >= AF));
      chk("almost_empty", int'(almost_empty), int'(q.size() <= AE));
      chk("rd_valid", int'(rd_valid), int'(m_rd_valid));
      chk("rd_data", int'(rd_data), int'(m_rd_data));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_unf));
`ifdef PARAM_SYNC_FIFO_SEG7_EN
      chk("seg_out", int'(seg_out), int'(m_seg));
`endif
    end
  end

  initial begin
    int wp, rp;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check_en = 1'b1;

    // Reset state pinned by literals
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_full", int'(almost_full), 0);

    // Write 1..5 then read back in order with one-cycle latency
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, W'(i), 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      chk("seq_rd_valid", int'(rd_valid), 1);
      chk("seq_rd_data", int'(rd_data), i);
    end
    step(1'b0, 1'b0, '0, 1'b0);
    chk("seq_empty", int'(empty), 1);
    chk("seq_valid_drop", int'(rd_valid), 0);
    chk("seq_hold", int'(rd_data), 5);

    // Fill to capacity, then one extra write overflows
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, W'($urandom), 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 128);
    step(1'b0, 1'b1, 4'hF, 1'b0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(count), 128);

    // Full with simultaneous read and write across pointer wrap
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < D; i++) step(1'b0, 1'b1, W'(i), 1'b0);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, W'(i + 3), 1'b1);
    chk("fullrw_count", int'(count), 128);
    chk("fullrw_ovf", int'(overflow), 0);
    chk("fullrw_unf", int'(underflow), 0);
    chk("fullrw_last", int'(rd_data), (199 - 128 + 3) % 16);

    // Empty with simultaneous read and write: write wins, no bypass
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 4'hA, 1'b1);
    chk("emptyrw_count", int'(count), 1);
    chk("emptyrw_valid", int'(rd_valid), 0);
    chk("emptyrw_unf", int'(underflow), 0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("emptyrw_data", int'(rd_data), 10);
    chk("emptyrw_valid2", int'(rd_valid), 1);

    // Reset mid-operation discards contents
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, W'($urandom), 1'b0);
    step(1'b1, 1'b1, 4'h7, 1'b0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("midrst_unf", int'(underflow), 1);
    chk("midrst_valid", int'(rd_valid), 0);

`ifdef PARAM_SYNC_FIFO_SEG7_EN
    step(1'b1, 1'b0, '0, 1'b0);
    chk("seg_reset", int'(seg_out), 7'b1111110);
    step(1'b0, 1'b1, 4'h3, 1'b0);
    step(1'b0, 1'b1, 4'hE, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seg_3", int'(seg_out), 7'b1111001);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seg_e", int'(seg_out), 7'b1001111);
`endif

    // Randomised traffic with phase-dependent bias to visit full and empty
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      case ((i / 250) % 4)
        0:       begin wp = 90; rp = 20; end
        1:       begin wp = 20; rp = 90; end
        2:       begin wp = 50; rp = 50; end
        default: begin wp = 95; rp = 95; end
      endcase
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 99) < wp), W'($urandom),
           ($urandom_range(0, 99) < rp));
    end

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
